// File: rtl/train_accuracy_monitor_if.sv
// Output-stream bus for train_accuracy_monitor: activation/ideal-bit lanes in, case statistics out.
// Optional case_sqerr signal present only when SQERR_EN is defined.
interface train_accuracy_monitor_if #(
   parameter int width     = 32,
   parameter int p         = 1,
   parameter int win       = 100,
   parameter int tot_width = 24
);
   localparam int RW = $clog2(win + 1);

   logic                   case_start;
   logic                   valid;
   logic [p*width-1:0]     a_out;
   logic [p-1:0]           y_out;
   logic                   case_done;
   logic                   case_correct;
   logic [RW-1:0]          recent_correct;
   logic                   window_full;
   logic [tot_width-1:0]   total_cases;
   logic [tot_width-1:0]   total_errors;
`ifdef SQERR_EN
   logic [2*width-1:0]     case_sqerr;
`endif

   modport master (
      output case_start, valid, a_out, y_out,
      input
`ifdef SQERR_EN
      case_sqerr,
`endif
      case_done, case_correct, recent_correct, window_full, total_cases, total_errors
   );

   modport slave (
      input  case_start, valid, a_out, y_out,
      output
`ifdef SQERR_EN
      case_sqerr,
`endif
      case_done, case_correct, recent_correct, window_full, total_cases, total_errors
   );
endinterface

// File: rtl/train_accuracy_monitor.sv
// Per-case correct/incorrect classifier (threshold 0.5) with sliding-window and saturating totals.
// Define SQERR_EN to add the per-case sum-of-squared-error output case_sqerr.
module train_accuracy_monitor #(
   parameter int width     = 32,
   parameter int frac_bits = 21,
   parameter int n_out     = 16,
   parameter int p         = 1,
   parameter int win       = 100,
   parameter int tot_width = 24
) (
   input  logic                     clk,
   input  logic                     reset_n,
   train_accuracy_monitor_if.slave  bus
);
   localparam int NB = n_out / p;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam int RW = $clog2(win + 1);
   localparam logic signed [width-1:0] HALF    = width'(1) << (frac_bits - 1);
   localparam logic [tot_width-1:0]    TOT_MAX = '1;

   logic [p-1:0]          w_lane_err;
   logic [BW-1:0]         r_beat, w_beat;
   logic                  r_case_err, w_err_base, w_beat_err, w_commit, w_new_correct;
   logic                  r_case_done, r_case_correct, r_full;
   logic [win-1:0]        r_window, w_window_next;
   logic                  w_oldest;
   logic [RW-1:0]         r_recent, r_commits;
   logic [tot_width-1:0]  r_total_cases, r_total_errors;

   for (genvar gi = 0; gi < p; gi++) begin : g_lane
      logic signed [width-1:0] w_a;
      assign w_a = bus.a_out[gi*width +: width];
      // Exactly-half is deliberately neither side of the threshold.
      assign w_lane_err[gi] = bus.y_out[gi] ? (w_a < HALF) : (w_a > HALF);
   end

   // case_start acts in its own cycle, so a coincident beat is beat 0 of the new case.
   assign w_beat        = bus.case_start ? '0 : r_beat;
   assign w_err_base    = ~bus.case_start & r_case_err;
   assign w_beat_err    = |w_lane_err;
   assign w_commit      = bus.valid && (w_beat == BW'(NB - 1));
   assign w_new_correct = ~(w_err_base | w_beat_err);
   assign w_oldest      = r_window[win-1];

   if (win > 1) begin : g_win_shift
      assign w_window_next = {r_window[win-2:0], w_new_correct};
   end else begin : g_win_single
      assign w_window_next = w_new_correct;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_beat         <= '0;
         r_case_err     <= 1'b0;
         r_case_done    <= 1'b0;
         r_case_correct <= 1'b0;
         r_window       <= '0;
         r_recent       <= '0;
         r_commits      <= '0;
         r_full         <= 1'b0;
         r_total_cases  <= '0;
         r_total_errors <= '0;
      end else begin
         r_case_done <= w_commit;
         if (w_commit) begin
            r_beat         <= '0;
            r_case_err     <= 1'b0;
            r_case_correct <= w_new_correct;
            r_window       <= w_window_next;
            r_recent       <= r_recent + RW'(w_new_correct) - RW'(w_oldest);
            if (!r_full) begin
               r_commits <= r_commits + RW'(1);
               if (r_commits == RW'(win - 1))
                  r_full <= 1'b1;
            end
            if (r_total_cases != TOT_MAX)
               r_total_cases <= r_total_cases + tot_width'(1);
            if (!w_new_correct && (r_total_errors != TOT_MAX))
               r_total_errors <= r_total_errors + tot_width'(1);
         end else if (bus.valid) begin
            r_beat     <= w_beat + BW'(1);
            r_case_err <= w_err_base | w_beat_err;
         end else if (bus.case_start) begin
            r_beat     <= '0;
            r_case_err <= 1'b0;
         end
      end
   end

   assign bus.case_done      = r_case_done;
   assign bus.case_correct   = r_case_correct;
   assign bus.recent_correct = r_recent;
   assign bus.window_full    = r_full;
   assign bus.total_cases    = r_total_cases;
   assign bus.total_errors   = r_total_errors;

`ifdef SQERR_EN
   localparam int DW = width + 2;
   localparam int SW = 2 * DW + $clog2(p + 1) + 1;
   localparam logic signed [DW-1:0] ONE_Y = DW'(1) << frac_bits;

   logic [2*width-1:0] r_sq_acc, r_case_sqerr, w_sq_base, w_sq_next;
   logic [SW-1:0]      w_sq_chain [p+1];

   assign w_sq_base     = bus.case_start ? '0 : r_sq_acc;
   assign w_sq_chain[0] = {{(SW-2*width){1'b0}}, w_sq_base};

   for (genvar gi = 0; gi < p; gi++) begin : g_sq
      logic signed [DW-1:0]   w_diff;
      logic signed [2*DW-1:0] w_diff_x, w_sq;
      assign w_diff   = {{2{bus.a_out[gi*width+width-1]}}, bus.a_out[gi*width +: width]}
                        - (bus.y_out[gi] ? ONE_Y : '0);
      assign w_diff_x = {{DW{w_diff[DW-1]}}, w_diff};
      assign w_sq     = w_diff_x * w_diff_x;
      assign w_sq_chain[gi+1] = w_sq_chain[gi] + SW'($unsigned(w_sq));
   end

   assign w_sq_next = (|w_sq_chain[p][SW-1:2*width]) ? '1 : w_sq_chain[p][2*width-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sq_acc     <= '0;
         r_case_sqerr <= '0;
      end else if (w_commit) begin
         r_case_sqerr <= w_sq_next;
         r_sq_acc     <= '0;
      end else if (bus.valid) begin
         r_sq_acc <= w_sq_next;
      end else if (bus.case_start) begin
         r_sq_acc <= '0;
      end
   end

   assign bus.case_sqerr = r_case_sqerr;
`endif
endmodule

// File: tb/tb_train_accuracy_monitor.sv
// Scoreboard bench for train_accuracy_monitor: expected case results queued at the final beat,
// compared when case_done appears; one line printed per committed case.
module tb_train_accuracy_monitor;
   localparam int WIDTH = 32, FRAC = 21, NOUT = 16, P = 1, WIN = 100, TOTW = 8;
   localparam int TOT_MAX = (1 << TOTW) - 1;
   localparam logic [31:0] A_HI   = 32'd1572864;   // 0.75
   localparam logic [31:0] A_LO   = 32'd524288;    // 0.25
   localparam logic [31:0] A_HALF = 32'd1048576;   // 0.5
   localparam logic [31:0] A_06   = 32'd1258291;   // ~0.6
   localparam logic [31:0] A_NEG1 = 32'hFFE00000;  // -1.0
   localparam logic signed [31:0] HALF_S = 32'sd1048576;

   typedef struct {
      bit          correct;
      int          recent;
      bit          full;
      int          tot;
      int          errs;
      logic [63:0] sq;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   train_accuracy_monitor_if #(.width(WIDTH), .p(P), .win(WIN), .tot_width(TOTW)) bus ();

   train_accuracy_monitor #(
      .width(WIDTH), .frac_bits(FRAC), .n_out(NOUT), .p(P), .win(WIN), .tot_width(TOTW)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   exp_t        sb[$];
   bit          hist[$];
   int          total = 0, bad = 0, cyc = 0;
   int          commits = 0, nerr = 0, m_beat = 0;
   bit          m_err = 0;
   logic [63:0] m_sq = '0;

   always @(posedge clk) cyc++;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   function automatic logic [63:0] sq_of(input logic [31:0] a, input bit y);
      logic signed [127:0] d;
      logic [127:0] s;
      d = 128'($signed(a)) - (y ? (128'sd1 <<< FRAC) : 128'sd0);
      s = d * d;
      return (s > 128'hFFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
   endfunction

   function automatic logic [63:0] sat_add(input logic [63:0] x, input logic [63:0] y);
      logic [64:0] s;
      s = {1'b0, x} + {1'b0, y};
      return s[64] ? 64'hFFFF_FFFF_FFFF_FFFF : s[63:0];
   endfunction

   function automatic void model_clear_case();
      m_err  = 0;
      m_beat = 0;
      m_sq   = '0;
   endfunction

   function automatic void model_commit(input bit correct);
      exp_t e;
      int   s;
      commits++;
      if (!correct) nerr++;
      hist.push_back(correct);
      if (hist.size() > WIN) void'(hist.pop_front());
      s = 0;
      foreach (hist[i]) s += int'(hist[i]);
      e.correct = correct;
      e.recent  = s;
      e.full    = (commits >= WIN);
      e.tot     = (commits > TOT_MAX) ? TOT_MAX : commits;
      e.errs    = (nerr > TOT_MAX) ? TOT_MAX : nerr;
      e.sq      = m_sq;
      e.cyc     = cyc + 1;
      sb.push_back(e);
      model_clear_case();
   endfunction

   task automatic beat(input logic [31:0] a, input bit y, input bit start);
      @(posedge clk);
      #1;
      bus.case_start = start;
      bus.valid      = 1'b1;
      bus.a_out      = a;
      bus.y_out      = y;
      if (start) model_clear_case();
      if ((!y && $signed(a) > HALF_S) || (y && $signed(a) < HALF_S)) m_err = 1;
      m_sq = sat_add(m_sq, sq_of(a, y));
      m_beat++;
      if (m_beat == NOUT) model_commit(!m_err);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.valid      = 1'b0;
         bus.case_start = 1'b0;
      end
   endtask

   task automatic start_only();
      @(posedge clk);
      #1;
      bus.case_start = 1'b1;
      bus.valid      = 1'b0;
      model_clear_case();
   endtask

   // lane >= 0: that beat uses (sa, sy); lane == -2: every beat is exactly 0.5.
   task automatic run_case(input int lane, input logic [31:0] sa, input bit sy,
                           input bit start, input int gap, input int nbeats);
      for (int i = 0; i < nbeats; i++) begin
         bit y;
         y = 1'($urandom_range(0, 1));
         if (i == lane)      beat(sa, sy, start && i == 0);
         else if (lane == -2) beat(A_HALF, y, start && i == 0);
         else                beat(y ? A_HI : A_LO, y, start && i == 0);
         if (gap > 0 && (i % gap) == gap - 1) idle(2);
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check_val({pfx, "_done"},    64'(bus.case_done), 64'd0);
      check_val({pfx, "_correct"}, 64'(bus.case_correct), 64'd0);
      check_val({pfx, "_recent"},  64'(bus.recent_correct), 64'd0);
      check_val({pfx, "_full"},    64'(bus.window_full), 64'd0);
      check_val({pfx, "_tot"},     64'(bus.total_cases), 64'd0);
      check_val({pfx, "_errs"},    64'(bus.total_errors), 64'd0);
`ifdef SQERR_EN
      check_val({pfx, "_sqerr"},   64'(bus.case_sqerr), 64'd0);
`endif
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.case_done) begin
         if (sb.size() == 0) begin
            check_val("spurious_done", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_val("latency",  64'(cyc), 64'(e.cyc));
            check_val("correct",  64'(bus.case_correct), 64'(e.correct));
            check_val("recent",   64'(bus.recent_correct), 64'(e.recent));
            check_val("full",     64'(bus.window_full), 64'(e.full));
            check_val("tot",      64'(bus.total_cases), 64'(e.tot));
            check_val("errs",     64'(bus.total_errors), 64'(e.errs));
`ifdef SQERR_EN
            check_val("sqerr",    bus.case_sqerr, e.sq);
`endif
            $display("case cyc=%0d correct=%0b recent=%0d full=%0b tot=%0d errs=%0d",
                     cyc, bus.case_correct, bus.recent_correct, bus.window_full,
                     bus.total_cases, bus.total_errors);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.case_start = 1'b0;
      bus.valid      = 1'b0;
      bus.a_out      = '0;
      bus.y_out      = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;

      // clean case, then exact-half lanes with y=1 and y=0
      run_case(-1, A_HI, 1'b1, 1'b0, 0, NOUT);
      idle(3);
      run_case(5, A_HALF, 1'b1, 1'b0, 0, NOUT);
      run_case(9, A_HALF, 1'b0, 1'b0, 0, NOUT);
      idle(2);
      // lane 3 at 0.6 with y=0 is an error; negative activations exercise signed compare
      run_case(3, A_06, 1'b0, 1'b0, 0, NOUT);
      run_case(2, A_NEG1, 1'b0, 1'b0, 0, NOUT);
      run_case(7, A_NEG1, 1'b1, 1'b0, 0, NOUT);
      idle(2);

      // all-half case: correct, squared error 16 * 0.25 = 4.0
      run_case(-2, A_HALF, 1'b0, 1'b0, 0, NOUT);
      idle(3);
      check_val("held_correct", 64'(bus.case_correct), 64'd1);
`ifdef SQERR_EN
      check_val("sqerr_4p0", bus.case_sqerr, 64'd4 << 42);
`endif

      // partial case with an error, discarded by case_start coincident with beat 0
      run_case(2, A_HI, 1'b0, 1'b0, 0, 7);
      run_case(-1, A_HI, 1'b1, 1'b1, 3, NOUT);
      idle(3);
      // partial case discarded by a standalone case_start
      run_case(1, A_LO, 1'b1, 1'b0, 0, 4);
      start_only();
      run_case(-1, A_HI, 1'b1, 1'b0, 5, NOUT);
      idle(3);
      check_val("pending_before_reset", 64'(sb.size()), 64'd0);

      // asynchronous reset in the middle of a case
      run_case(-1, A_HI, 1'b1, 1'b0, 0, 5);
      @(negedge clk);
      #2;
      bus.valid      = 1'b0;
      bus.case_start = 1'b0;
      reset_n        = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      sb.delete();
      hist.delete();
      commits = 0;
      nerr    = 0;
      model_clear_case();
      @(negedge clk);
      reset_n = 1'b1;

      // 150 alternating correct/incorrect cases fill and slide the window
      for (int k = 0; k < 150; k++) begin
         if (k % 2 == 1) run_case(3, A_06, 1'b0, 1'b0, 0, NOUT);
         else            run_case(-1, A_HI, 1'b1, 1'b0, 0, NOUT);
      end
      idle(3);
      check_val("recent_after_150", 64'(bus.recent_correct), 64'd50);
      check_val("full_after_150",   64'(bus.window_full), 64'd1);

      // incorrect cases until both totals saturate
      for (int k = 0; k < 190; k++) run_case(0, A_06, 1'b0, 1'b0, 0, NOUT);
      idle(5);
      check_val("tot_saturated",  64'(bus.total_cases), 64'(TOT_MAX));
      check_val("errs_saturated", 64'(bus.total_errors), 64'(TOT_MAX));
      check_val("recent_all_bad", 64'(bus.recent_correct), 64'd0);
      check_val("pending_cases",  64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
